// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiply is radix-2 shift-add and divide is restoring division. Both work on operand
// magnitudes, one bit per cycle, and apply sign correction when the result is loaded.
// Division by zero and signed overflow finish in one cycle without entering CALC.
module mul_div_unit #(
  parameter int unsigned width = 32,
  parameter int unsigned regs  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               funct3,
  input  logic [width-1:0]         op_a,
  input  logic [width-1:0]         op_b,
  input  logic [$clog2(regs)-1:0]  rd_in,
  output logic                     busy,
  output logic                     done,
  output logic [width-1:0]         result,
  output logic [$clog2(regs)-1:0]  rd_out
);

  localparam int unsigned cntw = $clog2(width);
  localparam logic [cntw-1:0] cnt_last = cntw'(width - 1);
  localparam logic [width-1:0] min_val = {1'b1, {(width-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

  state_t          state;
  logic [cntw-1:0] cnt;
  logic [2:0]      fn;
  logic            sign_a;
  logic            sign_b;
  // acc: high product half / partial remainder
  // lo: multiplier shifting out, product low half shifting in / dividend out, quotient in
  logic [width-1:0] acc;
  logic [width-1:0] lo;
  logic [width-1:0] mcand;   // multiplicand or divisor magnitude

  logic             a_signed, b_signed;
  logic             in_neg_a, in_neg_b;
  logic [width-1:0] in_mag_a, in_mag_b;
  logic             in_div_zero, in_ovf, special;
  logic [width-1:0] special_res;

  logic [width:0]     mul_sum;
  logic [width:0]     div_trial;
  logic [width-1:0]   acc_nxt, lo_nxt;
  logic [2*width-1:0] prod;
  logic [width-1:0]   quo, rem;
  logic [width-1:0]   final_res;

  // Decode operand signedness, magnitudes and the single-cycle special cases.
  always_comb begin
    // MULHU, DIVU, REMU (x11, 1x1) treat both operands as unsigned
    a_signed    = ~(funct3[0] & (funct3[1] | funct3[2]));
    b_signed    = a_signed & (funct3 != 3'b010);
    in_neg_a    = a_signed & op_a[width-1];
    in_neg_b    = b_signed & op_b[width-1];
    in_mag_a    = in_neg_a ? -op_a : op_a;
    in_mag_b    = in_neg_b ? -op_b : op_b;
    in_div_zero = funct3[2] & (op_b == '0);
    in_ovf      = funct3[2] & ~funct3[0] & (op_a == min_val) & (op_b == '1);
    special     = in_div_zero | in_ovf;
    if (in_div_zero) begin
      special_res = funct3[1] ? op_a : '1;
    end else begin
      special_res = funct3[1] ? '0 : op_a;
    end
  end

  // One iteration step, plus the sign-corrected result that is loaded on the last step.
  always_comb begin
    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
    // Partial remainder stays below the divisor, so the top bit of the trial is its sign
    div_trial = {acc, lo[width-1]} - {1'b0, mcand};
    if (fn[2]) begin
      acc_nxt = div_trial[width] ? {acc[width-2:0], lo[width-1]} : div_trial[width-1:0];
      lo_nxt  = {lo[width-2:0], ~div_trial[width]};
    end else begin
      acc_nxt = mul_sum[width:1];
      lo_nxt  = {mul_sum[0], lo[width-1:1]};
    end
    prod = {acc_nxt, lo_nxt};
    if (sign_a ^ sign_b) begin
      prod = -prod;
    end
    quo = (sign_a ^ sign_b) ? -lo_nxt : lo_nxt;
    rem = sign_a ? -acc_nxt : acc_nxt;
    if (fn[2]) begin
      final_res = fn[1] ? rem : quo;
    end else begin
      final_res = (fn[1:0] == 2'b00) ? prod[width-1:0] : prod[2*width-1:width];
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= StIdle;
      cnt    <= '0;
      fn     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      lo     <= '0;
      mcand  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            fn     <= funct3;
            rd_out <= rd_in;
            sign_a <= in_neg_a;
            sign_b <= in_neg_b;
            cnt    <= '0;
            busy   <= 1'b1;
            if (special) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= StDone;
            end else begin
              acc   <= '0;
              lo    <= funct3[2] ? in_mag_a : in_mag_b;
              mcand <= funct3[2] ? in_mag_b : in_mag_a;
              state <= StCalc;
            end
          end
        end
        StCalc: begin
          acc <= acc_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == cnt_last) begin
            result <= final_res;
            done   <= 1'b1;
            state  <= StDone;
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomised bench for mul_div_unit with a result scoreboard.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  mul_div_unit #(.width(32), .regs(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc++;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res);
    exp_t e;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    start  = 1'b1;
    e.res  = exp_res;
    e.rd   = rd;
    sb.push_back(e);
    cyc = 0;
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    check({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_res"}, 64'(result), 64'(e.res));
      check({tag, "_rd"}, 64'(rd_out), 64'(e.rd));
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int lat);
    bit got;
    got = 1'b0;
    issue(f, a, b, rd, exp_res);
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (done) begin
        got = 1'b1;
        check({tag, "_lat"}, 64'(cyc), 64'(lat));
        check({tag, "_busy_done"}, 64'(busy), 64'd1);
        check_done(tag);
      end else begin
        check({tag, "_busy"}, 64'(busy), 64'd1);
      end
    end
    check({tag, "_seen"}, 64'(got), 64'd1);
    tick();
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_done"}, 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb64, ua, ub, p;
    sa   = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    case (f)
      3'b000: begin p = sa * sb64; return p[31:0]; end
      3'b001: begin p = sa * sb64; return p[63:32]; end
      3'b010: begin p = sa * ub;   return p[63:32]; end
      3'b011: begin p = ua * ub;   return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int          rlat;

    rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_rd", 64'(rd_out), 64'd0);
    rst = 1'b0;
    tick();

    // Multiply variants
    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 33);

    // Divide variants
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33);
    run_op("divu", 3'b101, 32'd100, 32'd7, 5'd12, 32'd14, 33);
    run_op("remu", 3'b111, 32'd100, 32'd7, 5'd13, 32'd2, 33);

    // Single-cycle special cases
    run_op("divu_z", 3'b101, 32'h1234, 32'd0, 5'd14, 32'hFFFF_FFFF, 1);
    run_op("rem_z", 3'b110, 32'h1234, 32'd0, 5'd15, 32'h1234, 1);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 1);

    // Starts while busy (mid-CALC and in DONE) are ignored
    issue(3'b100, 32'd50, 32'd5, 5'd3, 32'd10);
    while (cyc < 33) begin
      if (cyc == 10) begin
        funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd7; start = 1'b1;
      end
      tick();
      if (cyc < 33) check("ign_nodone", 64'(done), 64'd0);
    end
    check("ign_done", 64'(done), 64'd1);
    check_done("ign");
    funct3 = 3'b011; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd9; start = 1'b1;
    tick();
    check("ign_busy34", 64'(busy), 64'd0);
    check("ign_done34", 64'(done), 64'd0);
    check("ign_hold_res", 64'(result), 64'd10);
    check("ign_hold_rd", 64'(rd_out), 64'd3);
    run_op("after_ign", 3'b101, 32'd100, 32'd7, 5'd4, 32'd14, 33);

    // Reset mid-CALC discards the operation
    issue(3'b100, 32'h1234, 32'd3, 5'd6, 32'h0611);
    while (cyc < 15) tick();
    rst = 1'b1;
    tick();
    sb.delete();
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_result", 64'(result), 64'd0);
    check("mrst_rd", 64'(rd_out), 64'd0);
    rst = 1'b0;
    tick();
    check("mrst_nodone", 64'(done), 64'd0);
    check("mrst_idle", 64'(busy), 64'd0);
    run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 5'd8, 32'd12, 33);

    // Randomised operations against the reference model
    for (int i = 0; i < 12; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'd0 : $urandom;
      if (i == 5) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      rlat = (rf[2] && (rb == 0 || (!rf[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)))
             ? 1 : 33;
      run_op("rand", rf, ra, rb, 5'(i), ref_res(rf, ra, rb), rlat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
